ifx_dig_data_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one DWIDTH data bus between NUM_REQ requesters. Each requester offers bursts over a valid/ready/last handshake. The arbiter locks the bus to one requester for a whole burst and drives a registered output stage toward the bus sink. It sits directly in front of the data bus, on the data bus UVC clock domain.

---
 rtl/ifx_dig_data_bus_arbiter.sv | 104 ++++++++++
 tb/tb_ifx_dig_data_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifx_dig_data_bus_arbiter.sv
// ifx_dig_data_bus_arbiter: round-robin arbiter sharing one data bus between NUM_REQ burst requesters
//   clk_i, rst_i          : bus clock, synchronous active-high reset
//   req_valid_i/_data_i/_last_i, req_ready_o : per-requester beat handshake (requester k data at [k*DWIDTH +: DWIDTH])
//   data_o/_valid_o/_last_o/_src_o, data_ready_i : registered bus output stage toward the sink
//   burst_err_o           : one-cycle pulse with the beat that force-released a grant at MAX_BURST
module ifx_dig_data_bus_arbiter #(
   parameter int DWIDTH    = 1,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16,
   localparam int SRCW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [DWIDTH-1:0]         data_o,
   output logic                      data_valid_o,
   output logic                      data_last_o,
   output logic [SRCW-1:0]           data_src_o,
   input  logic                      data_ready_i,
   output logic                      burst_err_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t            state_q, state_d;
   logic [SRCW-1:0]   rr_ptr_q, rr_ptr_d, gnt_id_q, gnt_id_d, src_q, src_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              valid_q, valid_d, last_q, last_d, err_q, err_d;
   logic              out_rdy, acc, at_max, rel, found;
   logic [SRCW-1:0]   pick, gnt_nxt;
   logic [SRCW:0]     cand;
   logic [DWIDTH-1:0] req_slice [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign req_slice[k] = req_data_i[k*DWIDTH +: DWIDTH];
   end

   // first valid requester at or after rr_ptr; the candidate index is reduced modulo NUM_REQ
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + (SRCW+1)'(i);
         if (cand >= (SRCW+1)'(NUM_REQ)) cand = cand - (SRCW+1)'(NUM_REQ);
         if (!found && req_valid_i[cand[SRCW-1:0]]) begin
            found = 1'b1;
            pick  = cand[SRCW-1:0];
         end
      end
   end

   always_comb begin
      out_rdy     = !valid_q | data_ready_i;
      acc         = (state_q == BUSY) & out_rdy & req_valid_i[gnt_id_q];
      at_max      = beat_cnt_q == 8'(MAX_BURST-1);
      rel         = acc & (req_last_i[gnt_id_q] | at_max);
      gnt_nxt     = (gnt_id_q == SRCW'(NUM_REQ-1)) ? '0 : gnt_id_q + 1'b1;
      req_ready_o = '0;
      if (state_q == BUSY) req_ready_o[gnt_id_q] = out_rdy;
      state_d     = (state_q == IDLE) ? (found ? BUSY : IDLE) : (rel ? IDLE : BUSY);
      rr_ptr_d    = rel ? gnt_nxt : rr_ptr_q;
      gnt_id_d    = (state_q == IDLE && found) ? pick : gnt_id_q;
      beat_cnt_d  = (state_q == IDLE) ? 8'd0 : acc ? beat_cnt_q + 8'd1 : beat_cnt_q;
      data_d      = acc ? req_slice[gnt_id_q] : data_q;
      src_d       = acc ? gnt_id_q : src_q;
      last_d      = acc ? (req_last_i[gnt_id_q] | at_max) : last_q;
      valid_d     = acc | (valid_q & !data_ready_i);
      // a release without the requester's own last flag can only be the MAX_BURST cut
      err_d       = rel & !req_last_i[gnt_id_q];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_id_q   <= '0;
         beat_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         src_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_id_q   <= gnt_id_d;
         beat_cnt_q <= beat_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         src_q      <= src_d;
         err_q      <= err_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign data_last_o  = last_q;
   assign data_src_o   = src_q;
   assign burst_err_o  = err_q;
endmodule

// File: tb/tb_ifx_dig_data_bus_arbiter.sv
// tb_ifx_dig_data_bus_arbiter: directed self-checking bench for the round-robin data bus arbiter
module tb_ifx_dig_data_bus_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int MB = 4;
   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic [NR-1:0]    req_valid_i = '0, req_last_i = '0, req_ready_o;
   logic [NR*DW-1:0] req_data_i = '0;
   logic [DW-1:0]    data_o;
   logic             data_valid_o, data_last_o, burst_err_o;
   logic             data_ready_i = 1'b1;
   logic [1:0]       data_src_o;
   int               tests = 0, fails = 0, cyc = 0, rx_n = 0, err_cnt = 0;
   logic [7:0]       txd [NR][16];
   logic             txl [NR][16];
   int               hd [NR], tl [NR];
   logic [NR-1:0]    hold = '0;
   logic [1:0]       rx_src [32];
   logic [7:0]       rx_dat [32];
   logic             rx_last [32], rx_err [32];
   int               rx_cyc [32];

   always #5 clk = ~clk;

   ifx_dig_data_bus_arbiter #(.DWIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
      .req_last_i(req_last_i), .req_ready_o(req_ready_o), .data_o(data_o),
      .data_valid_o(data_valid_o), .data_last_o(data_last_o), .data_src_o(data_src_o),
      .data_ready_i(data_ready_i), .burst_err_o(burst_err_o));

   task automatic push(input int k, input logic [7:0] d, input logic l);
      txd[k][tl[k]] = d;
      txl[k][tl[k]] = l;
      tl[k]++;
   endtask

   task automatic drive();
      for (int k = 0; k < NR; k++) begin
         req_valid_i[k]          = (hd[k] < tl[k]) && !hold[k];
         req_data_i[k*DW +: DW]  = (hd[k] < tl[k]) ? txd[k][hd[k]] : 8'h00;
         req_last_i[k]           = (hd[k] < tl[k]) ? txl[k][hd[k]] : 1'b0;
      end
   endtask

   // sample handshakes at the falling edge, update requester queues just after the rising edge
   task automatic tick();
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = req_valid_i & req_ready_o;
      if (data_valid_o && data_ready_i && rx_n < 32) begin
         rx_src[rx_n]  = data_src_o;
         rx_dat[rx_n]  = data_o;
         rx_last[rx_n] = data_last_o;
         rx_err[rx_n]  = burst_err_o;
         rx_cyc[rx_n]  = cyc;
         rx_n++;
      end
      if (burst_err_o) err_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NR; k++) if (acc[k]) hd[k]++;
      drive();
   endtask

   task automatic run_until(input int n, input int budget);
      int b = 0;
      while (rx_n < n && b < budget) begin
         tick();
         b++;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      data_ready_i = 1'b1;
      hold = '0;
      for (int k = 0; k < NR; k++) begin
         hd[k] = 0;
         tl[k] = 0;
      end
      drive();
      tick();
      tick();
      rst_i = 1'b0;
      rx_n = 0;
      err_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      tests += 6;
      if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL reset req_ready_o: got %b want 0000", req_ready_o); end
      if (data_valid_o !== 1'b0) begin fails++; $display("FAIL reset data_valid_o: got %b want 0", data_valid_o); end
      if (data_o !== 8'h00) begin fails++; $display("FAIL reset data_o: got %h want 00", data_o); end
      if (data_last_o !== 1'b0) begin fails++; $display("FAIL reset data_last_o: got %b want 0", data_last_o); end
      if (data_src_o !== 2'd0) begin fails++; $display("FAIL reset data_src_o: got %0d want 0", data_src_o); end
      if (burst_err_o !== 1'b0) begin fails++; $display("FAIL reset burst_err_o: got %b want 0", burst_err_o); end
   endtask

   task automatic test_round_robin();
      logic [10:0] e [4];
      do_reset();
      push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
      push(2, 8'h20, 1'b1); push(2, 8'h21, 1'b1);
      drive();
      run_until(4, 40);
      e[0] = {2'd0, 1'b1, 8'h10}; e[1] = {2'd2, 1'b1, 8'h20};
      e[2] = {2'd0, 1'b1, 8'h11}; e[3] = {2'd2, 1'b1, 8'h21};
      tests++;
      if (rx_n !== 4) begin fails++; $display("FAIL rr beat count: got %0d want 4", rx_n); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL rr beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
   endtask

   task automatic test_burst();
      logic [10:0] e [4];
      do_reset();
      push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
      push(3, 8'hB1, 1'b1);
      drive();
      run_until(4, 40);
      e[0] = {2'd1, 1'b0, 8'hA1}; e[1] = {2'd1, 1'b0, 8'hA2};
      e[2] = {2'd1, 1'b1, 8'hA3}; e[3] = {2'd3, 1'b1, 8'hB1};
      tests++;
      if (rx_n !== 4) begin fails++; $display("FAIL burst beat count: got %0d want 4", rx_n); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL burst beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
      tests += 3;
      if (rx_cyc[1] - rx_cyc[0] !== 1) begin fails++; $display("FAIL burst gap A1-A2: got %0d want 1", rx_cyc[1] - rx_cyc[0]); end
      if (rx_cyc[2] - rx_cyc[1] !== 1) begin fails++; $display("FAIL burst gap A2-A3: got %0d want 1", rx_cyc[2] - rx_cyc[1]); end
      if (rx_cyc[3] - rx_cyc[2] !== 2) begin fails++; $display("FAIL burst gap A3-B1: got %0d want 2", rx_cyc[3] - rx_cyc[2]); end
   endtask

   task automatic test_backpressure();
      logic [10:0] e [4];
      do_reset();
      push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b0); push(2, 8'hC4, 1'b1);
      drive();
      run_until(1, 20);
      data_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         tests += 2;
         if ({data_valid_o, data_src_o, data_last_o, data_o} !== {1'b1, 2'd2, 1'b0, 8'hC2}) begin
            fails++;
            $display("FAIL stall hold cycle %0d: got valid=%b src=%0d last=%b data=%h want valid=1 src=2 last=0 data=c2",
                     c, data_valid_o, data_src_o, data_last_o, data_o);
         end
         if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL stall req_ready_o cycle %0d: got %b want 0000", c, req_ready_o); end
      end
      data_ready_i = 1'b1;
      run_until(4, 20);
      repeat (3) tick();
      e[0] = {2'd2, 1'b0, 8'hC1}; e[1] = {2'd2, 1'b0, 8'hC2};
      e[2] = {2'd2, 1'b0, 8'hC3}; e[3] = {2'd2, 1'b1, 8'hC4};
      tests++;
      if (rx_n !== 4) begin fails++; $display("FAIL stall beat count: got %0d want 4", rx_n); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL stall beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
   endtask

   task automatic test_max_burst();
      logic [10:0] e [7];
      do_reset();
      for (int i = 0; i < 6; i++) push(0, 8'hD0 + 8'(i), 1'b0);
      push(1, 8'hE0, 1'b1);
      drive();
      run_until(7, 60);
      e[0] = {2'd0, 1'b0, 8'hD0}; e[1] = {2'd0, 1'b0, 8'hD1};
      e[2] = {2'd0, 1'b0, 8'hD2}; e[3] = {2'd0, 1'b1, 8'hD3};
      e[4] = {2'd1, 1'b1, 8'hE0}; e[5] = {2'd0, 1'b0, 8'hD4};
      e[6] = {2'd0, 1'b0, 8'hD5};
      tests++;
      if (rx_n !== 7) begin fails++; $display("FAIL maxburst beat count: got %0d want 7", rx_n); end
      for (int i = 0; i < 7; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL maxburst beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
      tests += 2;
      if (err_cnt !== 1) begin fails++; $display("FAIL maxburst err pulses: got %0d want 1", err_cnt); end
      if (rx_err[3] !== 1'b1) begin fails++; $display("FAIL maxburst err with beat 4: got %b want 1", rx_err[3]); end
   endtask

   task automatic test_drop_valid();
      logic [10:0] e [5];
      do_reset();
      push(2, 8'hF1, 1'b0); push(2, 8'hF2, 1'b0); push(2, 8'hF3, 1'b0); push(2, 8'hF4, 1'b1);
      drive();
      run_until(1, 20);
      hold[2] = 1'b1;
      push(0, 8'h61, 1'b1);
      drive();
      repeat (3) tick();
      tests += 3;
      if (data_valid_o !== 1'b0) begin fails++; $display("FAIL drop data_valid_o: got %b want 0", data_valid_o); end
      if (data_src_o !== 2'd2) begin fails++; $display("FAIL drop data_src_o: got %0d want 2", data_src_o); end
      if (req_ready_o !== 4'b0100) begin fails++; $display("FAIL drop req_ready_o: got %b want 0100", req_ready_o); end
      hold[2] = 1'b0;
      drive();
      run_until(5, 30);
      e[0] = {2'd2, 1'b0, 8'hF1}; e[1] = {2'd2, 1'b0, 8'hF2};
      e[2] = {2'd2, 1'b0, 8'hF3}; e[3] = {2'd2, 1'b1, 8'hF4};
      e[4] = {2'd0, 1'b1, 8'h61};
      tests++;
      if (rx_n !== 5) begin fails++; $display("FAIL drop beat count: got %0d want 5", rx_n); end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL drop beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [10:0] e [2];
      do_reset();
      push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b0); push(1, 8'h74, 1'b1);
      drive();
      run_until(2, 20);
      rst_i = 1'b1;
      tick();
      tests += 6;
      if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL midrst req_ready_o: got %b want 0000", req_ready_o); end
      if (data_valid_o !== 1'b0) begin fails++; $display("FAIL midrst data_valid_o: got %b want 0", data_valid_o); end
      if (data_o !== 8'h00) begin fails++; $display("FAIL midrst data_o: got %h want 00", data_o); end
      if (data_last_o !== 1'b0) begin fails++; $display("FAIL midrst data_last_o: got %b want 0", data_last_o); end
      if (data_src_o !== 2'd0) begin fails++; $display("FAIL midrst data_src_o: got %0d want 0", data_src_o); end
      if (burst_err_o !== 1'b0) begin fails++; $display("FAIL midrst burst_err_o: got %b want 0", burst_err_o); end
      rst_i = 1'b0;
      for (int k = 0; k < NR; k++) begin
         hd[k] = 0;
         tl[k] = 0;
      end
      push(3, 8'h91, 1'b1);
      push(1, 8'h81, 1'b1);
      rx_n = 0;
      drive();
      run_until(2, 20);
      e[0] = {2'd1, 1'b1, 8'h81};
      e[1] = {2'd3, 1'b1, 8'h91};
      tests++;
      if (rx_n !== 2) begin fails++; $display("FAIL midrst beat count: got %0d want 2", rx_n); end
      for (int i = 0; i < 2; i++) begin
         tests++;
         if ({rx_src[i], rx_last[i], rx_dat[i]} !== e[i]) begin
            fails++;
            $display("FAIL midrst beat %0d: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     i, rx_src[i], rx_last[i], rx_dat[i], e[i][10:9], e[i][8], e[i][7:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst();
      test_backpressure();
      test_max_burst();
      test_drop_valid();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
